// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU and its request arbiter.
//   alu_op_e      : RV32I ALU operation codes (0..9); codes 10..15 are unsupported
//   slot_state_e  : occupancy of the single registered result slot
//   op_supported  : true for the ten defined operation codes
package alu_pkg;

  localparam int ALU_OP_W     = 4;
  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  function automatic logic op_supported(logic [ALU_OP_W-1:0] op);
    return op <= ALU_AND;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between NUM_REQ requesters and the
// shared-ALU arbiter.
//   req_valid/req_ready : per-requester handshake (ready is a one-hot grant)
//   req_op/req_a/req_b  : per-requester operation and operands
//   rsp_valid/rsp_ready : result slot handshake
//   rsp_id/rsp_data/rsp_err : owner, value and unsupported-op flag of the result
//   op_count            : running count of accepted operations
// Modports: master = requester/consumer side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = alu_pkg::XLEN_DEFAULT
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                         req_valid;
  logic [NUM_REQ-1:0]                         req_ready;
  logic [NUM_REQ-1:0][alu_pkg::ALU_OP_W-1:0]  req_op;
  logic [NUM_REQ-1:0][XLEN-1:0]               req_a;
  logic [NUM_REQ-1:0][XLEN-1:0]               req_b;
  logic                                       rsp_valid;
  logic                                       rsp_ready;
  logic [ID_W-1:0]                            rsp_id;
  logic [XLEN-1:0]                            rsp_data;
  logic                                       rsp_err;
  logic [31:0]                                op_count;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, op_count
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, op_count
  );

endinterface

// File: rtl/alu.sv
// alu: combinational RV32I integer ALU.
//   rs1_val, rs2_val : operands
//   alu_op           : alu_op_e code; unsupported codes produce zero
//   rd_val           : result
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0]     rs1_val,
  input  logic [XLEN-1:0]     rs2_val,
  input  logic [ALU_OP_W-1:0] alu_op,
  output logic [XLEN-1:0]     rd_val
);

  localparam int SHAMT_W = $clog2(XLEN);

  logic [SHAMT_W-1:0] shamt;

  assign shamt = rs2_val[SHAMT_W-1:0];

  always_comb begin
    rd_val = '0;
    case (alu_op_e'(alu_op))
      ALU_ADD:  rd_val = rs1_val + rs2_val;
      ALU_SUB:  rd_val = rs1_val - rs2_val;
      ALU_SLL:  rd_val = rs1_val << shamt;
      ALU_SLT:  rd_val = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(rs2_val)};
      ALU_SLTU: rd_val = {{(XLEN-1){1'b0}}, rs1_val < rs2_val};
      ALU_XOR:  rd_val = rs1_val ^ rs2_val;
      ALU_SRL:  rd_val = rs1_val >> shamt;
      ALU_SRA:  rd_val = $unsigned($signed(rs1_val) >>> shamt);
      ALU_OR:   rd_val = rs1_val | rs2_val;
      ALU_AND:  rd_val = rs1_val & rs2_val;
      default:  rd_val = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req       : request vector
//   rr_ptr    : index with highest priority this cycle
//   grant     : one-hot grant (zero when no request)
//   grant_id  : encoded index of the grant
//   any_grant : some request was granted
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_grant
);

  // (base + off) mod NUM_REQ; base is always < NUM_REQ so one subtraction suffices.
  function automatic logic [ID_W-1:0] wrap_idx(logic [ID_W-1:0] base, int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = wrap_idx(rr_ptr, k);
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant_id   = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between NUM_REQ requesters with a
// round-robin grant and a single registered result slot (one cycle latency).
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : alu_arbiter_if.slave (requests in, grant and result out)
//
// Slot FSM
//   state | meaning
//   EMPTY | no result held; any valid request may be accepted
//   FULL  | result held on rsp_*; accept only when the consumer drains this cycle
module alu_arbiter
  import alu_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int XLEN    = XLEN_DEFAULT,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic           clk,
  input  logic           rst,
  alu_arbiter_if.slave   bus
);

  slot_state_e           state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q;
  logic [NUM_REQ-1:0]    req_elig;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_id;
  logic                  any_grant;
  logic                  can_accept;
  logic                  accept;
  logic [ALU_OP_W-1:0]   sel_op;
  logic [XLEN-1:0]       sel_a;
  logic [XLEN-1:0]       sel_b;
  logic [XLEN-1:0]       alu_result;
  logic [XLEN-1:0]       rsp_data_q;
  logic [ID_W-1:0]       rsp_id_q;
  logic                  rsp_err_q;
  logic [31:0]           op_count_q;

  // A full slot can take a new result only when it is being drained this cycle.
  assign can_accept = (state_q == EMPTY) || bus.rsp_ready;
  // Requests are masked during reset so no grant is visible while rst is high.
  assign req_elig   = (can_accept && !rst) ? bus.req_valid : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req_elig),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_id  (grant_id),
    .any_grant (any_grant)
  );

  assign accept        = any_grant;
  assign bus.req_ready = grant;

  assign sel_op = bus.req_op[grant_id];
  assign sel_a  = bus.req_a[grant_id];
  assign sel_b  = bus.req_b[grant_id];

  alu #(.XLEN(XLEN)) u_alu (
    .rs1_val (sel_a),
    .rs2_val (sel_b),
    .alu_op  (sel_op),
    .rd_val  (alu_result)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL: begin
        if (accept)             state_d = FULL;
        else if (bus.rsp_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      rr_ptr_q   <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
      rsp_err_q  <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rsp_data_q <= alu_result;
        rsp_id_q   <= grant_id;
        rsp_err_q  <= !op_supported(sel_op);
        rr_ptr_q   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        op_count_q <= op_count_q + 32'd1;
      end
    end
  end

  assign bus.rsp_valid = (state_q == FULL);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.op_count  = op_count_q;

endmodule
